// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one RSA modexp core among NUM_REQ
// requesters, with a completion watchdog and a tagged valid/ready response.
module rsa_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_number,
  input  logic [16*NUM_REQ-1:0]   req_key,
  input  logic [16*NUM_REQ-1:0]   req_n,
  output logic                    core_start,
  output logic [15:0]             core_number,
  output logic [15:0]             core_key,
  output logic [15:0]             core_n,
  input  logic [15:0]             core_result,
  input  logic                    core_finished,
  input  logic                    core_busy,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] gnt;
  logic            found;
  logic            grant;
  logic [16:0]     cnt;
  logic [16:0]     cnt_nxt;
  logic            tmo;

  // Scan from the requester after the last one served, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = ID_W'(idx);
      end
    end
  end

  assign grant = (state == IDLE) && !core_busy && found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt] = 1'b1;
  end

  // The compare uses the incremented count so the response rises
  // exactly TIMEOUT+1 cycles after the start pulse.
  assign cnt_nxt = cnt + 17'd1;
  assign tmo     = (cnt_nxt == 17'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= ID_W'(NUM_REQ - 1);
      core_start  <= 1'b0;
      core_number <= '0;
      core_key    <= '0;
      core_n      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      cnt         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            rsp_id      <= gnt;
            core_number <= req_number[16*int'(gnt) +: 16];
            core_key    <= req_key[16*int'(gnt) +: 16];
            core_n      <= req_n[16*int'(gnt) +: 16];
            core_start  <= 1'b1;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_nxt;
          if (core_finished) begin
            rsp_data  <= core_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (tmo) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last      <= rsp_id;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Bench for rsa_core_arbiter: unit 0 uses the default watchdog, unit 1 a
// 20-cycle watchdog; each unit has its own behavioural core stub.
module tb_rsa_core_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid[2];
  logic [N-1:0]    req_ready[2];
  logic [16*N-1:0] req_number[2];
  logic [16*N-1:0] req_key[2];
  logic [16*N-1:0] req_n[2];
  logic            core_start[2];
  logic [15:0]     core_number[2];
  logic [15:0]     core_key[2];
  logic [15:0]     core_n[2];
  logic [15:0]     core_result[2];
  logic            core_finished[2];
  logic            core_busy[2];
  logic            rsp_valid[2];
  logic            rsp_ready[2];
  logic [1:0]      rsp_id[2];
  logic [15:0]     rsp_data[2];
  logic            rsp_err[2];
  logic            busy[2];

  int          n_chk  = 0;
  int          n_fail = 0;
  int          viol   = 0;
  int          stub_lat[2];
  bit          stub_on[2];
  int          scnt[2];
  logic        sseen[2];
  logic [15:0] sres[2];

  function automatic logic [15:0] modexp(input logic [15:0] b,
                                         input logic [15:0] e,
                                         input logic [15:0] m);
    logic [31:0] r;
    logic [31:0] x;
    r = 32'd1 % {16'd0, m};
    x = {16'd0, b} % {16'd0, m};
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % {16'd0, m};
      x = (x * x) % {16'd0, m};
    end
    return r[15:0];
  endfunction

  for (genvar u = 0; u < 2; u++) begin : g_u
    rsa_core_arbiter #(
      .NUM_REQ(N),
      .ID_W(2),
      .TIMEOUT(u == 0 ? 1023 : 20)
    ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid[u]),
      .req_ready(req_ready[u]),
      .req_number(req_number[u]),
      .req_key(req_key[u]),
      .req_n(req_n[u]),
      .core_start(core_start[u]),
      .core_number(core_number[u]),
      .core_key(core_key[u]),
      .core_n(core_n[u]),
      .core_result(core_result[u]),
      .core_finished(core_finished[u]),
      .core_busy(core_busy[u]),
      .rsp_valid(rsp_valid[u]),
      .rsp_ready(rsp_ready[u]),
      .rsp_id(rsp_id[u]),
      .rsp_data(rsp_data[u]),
      .rsp_err(rsp_err[u]),
      .busy(busy[u])
    );

    // Core stub: finished pulses stub_lat cycles after start; 0 = never.
    always begin
      @(negedge clk);
      sseen[u] = core_start[u];
      @(posedge clk);
      #1;
      if (stub_on[u]) begin
        core_finished[u] = 1'b0;
        if (sseen[u]) begin
          core_busy[u] = 1'b1;
          scnt[u] = stub_lat[u];
          sres[u] = modexp(core_number[u], core_key[u], core_n[u]);
        end
        if (scnt[u] > 0) begin
          scnt[u]--;
          if (scnt[u] == 0) begin
            core_finished[u] = 1'b1;
            core_result[u]   = sres[u];
            core_busy[u]     = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit cond(input int u, input int kind);
    case (kind)
      0:       return req_ready[u] != '0;
      1:       return rsp_valid[u] === 1'b1;
      default: return core_finished[u] === 1'b1;
    endcase
  endfunction

  // Starts at the drive point, returns at the sampling point of the hit.
  task automatic wait_for(input int u, input int kind, input int lim,
                          output int cyc);
    cyc = 0;
    smp();
    if (busy[u] === 1'b1 && req_ready[u] != '0) viol++;
    while (!cond(u, kind) && cyc < lim) begin
      step();
      smp();
      if (busy[u] === 1'b1 && req_ready[u] != '0) viol++;
      cyc++;
    end
    n_chk++;
    if (!cond(u, kind)) begin
      n_fail++;
      $display("FAIL wait_%0d unit %0d: not seen in %0d cycles", kind, u, lim);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u]     = '0;
      rsp_ready[u]     = 1'b1;
      core_finished[u] = 1'b0;
      core_busy[u]     = 1'b0;
      core_result[u]   = '0;
      scnt[u]          = 0;
      stub_on[u]       = 1'b0;
      stub_lat[u]      = 1;
    end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int u, input int i, input logic [15:0] a,
                         input logic [15:0] k, input logic [15:0] m);
    req_number[u][16*i +: 16] = a;
    req_key[u][16*i +: 16]    = k;
    req_n[u][16*i +: 16]      = m;
  endtask

  task automatic chk_reset_vals(input int u, input string tag);
    chk({tag, "_req_ready"}, req_ready[u], 0);
    chk({tag, "_core_start"}, core_start[u], 0);
    chk({tag, "_core_number"}, core_number[u], 0);
    chk({tag, "_core_key"}, core_key[u], 0);
    chk({tag, "_core_n"}, core_n[u], 0);
    chk({tag, "_rsp_valid"}, rsp_valid[u], 0);
    chk({tag, "_rsp_id"}, rsp_id[u], 0);
    chk({tag, "_rsp_data"}, rsp_data[u], 0);
    chk({tag, "_rsp_err"}, rsp_err[u], 0);
    chk({tag, "_busy"}, busy[u], 0);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int lst);
    for (int k = 1; k <= N; k++)
      if (v[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] v;
    int           id;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int c;
    int bad;
    tbl[0] = '{4'b1111, 0};
    tbl[1] = '{4'b1111, 1};
    tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1111, 3};
    tbl[4] = '{4'b1111, 0};
    tbl[5] = '{4'b1000, 3};
    tbl[6] = '{4'b0101, 0};
    tbl[7] = '{4'b0101, 2};
    tbl[8] = '{4'b0011, 0};
    tbl[9] = '{4'b0010, 1};
    for (int u = 0; u < 2; u++) begin
      req_number[u] = '0;
      req_key[u]    = '0;
      req_n[u]      = '0;
    end

    // Single request and reset values
    do_reset();
    smp();
    chk_reset_vals(0, "rst");
    step();
    stub_on[0]  = 1'b1;
    stub_lat[0] = 40;
    set_ops(0, 2, 16'd2790, 16'd2753, 16'd3233);
    req_valid[0] = 4'b0100;
    smp();
    chk("single_ready", req_ready[0], 4'b0100);
    step();
    req_valid[0] = '0;
    smp();
    chk("single_start", core_start[0], 1);
    chk("single_number", core_number[0], 2790);
    chk("single_key", core_key[0], 2753);
    chk("single_n", core_n[0], 3233);
    step();
    smp();
    chk("single_start_pulse", core_start[0], 0);
    chk("single_no_ready", req_ready[0], 0);
    step();
    wait_for(0, 2, 100, c);
    chk("single_rsp_early", rsp_valid[0], 0);
    step();
    smp();
    chk("single_rsp_valid", rsp_valid[0], 1);
    chk("single_rsp_id", rsp_id[0], 2);
    chk("single_rsp_data", rsp_data[0], 65);
    chk("single_rsp_err", rsp_err[0], 0);
    step();
    smp();
    chk("single_done_valid", rsp_valid[0], 0);
    chk("single_done_busy", busy[0], 0);

    // Round-robin table
    step();
    do_reset();
    stub_on[0]  = 1'b1;
    stub_lat[0] = 3;
    for (int i = 0; i < N; i++)
      set_ops(0, i, 16'(100 + 13 * i), 16'(5 + 2 * i), 16'(1000 + 37 * i));
    for (int k = 0; k < 10; k++) begin
      req_valid[0] = tbl[k].v;
      wait_for(0, 0, 60, c);
      chk($sformatf("rr_grant_%0d", k), req_ready[0], 4'b0001 << tbl[k].id);
      step();
      smp();
      chk($sformatf("rr_number_%0d", k), core_number[0],
          100 + 13 * tbl[k].id);
      step();
      wait_for(0, 1, 60, c);
      chk($sformatf("rr_id_%0d", k), rsp_id[0], tbl[k].id);
      chk($sformatf("rr_data_%0d", k), rsp_data[0],
          modexp(16'(100 + 13 * tbl[k].id), 16'(5 + 2 * tbl[k].id),
                 16'(1000 + 37 * tbl[k].id)));
      step();
    end

    // Watchdog on unit 1
    do_reset();
    stub_on[1]  = 1'b1;
    stub_lat[1] = 0;
    set_ops(1, 0, 16'd7, 16'd3, 16'd11);
    req_valid[1] = 4'b0001;
    wait_for(1, 0, 10, c);
    chk("wd_grant", req_ready[1], 4'b0001);
    step();
    smp();
    chk("wd_start", core_start[1], 1);
    step();
    wait_for(1, 1, 60, c);
    chk("wd_latency", c, 20);
    chk("wd_err", rsp_err[1], 1);
    chk("wd_data", rsp_data[1], 0);
    chk("wd_id", rsp_id[1], 0);
    bad = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      smp();
      if (req_ready[1] != '0 || busy[1] !== 1'b0) bad++;
    end
    chk("wd_holdoff", bad, 0);
    step();
    stub_on[1]       = 1'b0;
    core_finished[1] = 1'b1;
    core_result[1]   = 16'h1234;
    smp();
    step();
    core_finished[1] = 1'b0;
    smp();
    chk("wd_stale_valid", rsp_valid[1], 0);
    chk("wd_stale_busy", busy[1], 0);
    chk("wd_stale_ready", req_ready[1], 0);
    step();
    core_busy[1] = 1'b0;
    stub_on[1]   = 1'b1;
    stub_lat[1]  = 5;
    smp();
    chk("wd_regrant", req_ready[1], 4'b0001);
    step();
    req_valid[1] = '0;
    wait_for(1, 1, 30, c);
    chk("wd_after_data", rsp_data[1], 2);
    chk("wd_after_err", rsp_err[1], 0);
    step();

    // Finished and timeout in the same cycle
    stub_lat[1] = 20;
    set_ops(1, 1, 16'd2790, 16'd2753, 16'd3233);
    req_valid[1] = 4'b0010;
    wait_for(1, 0, 10, c);
    chk("coll_grant", req_ready[1], 4'b0010);
    step();
    req_valid[1] = '0;
    smp();
    chk("coll_start", core_start[1], 1);
    step();
    wait_for(1, 2, 40, c);
    chk("coll_at_timeout", c, 19);
    step();
    smp();
    chk("coll_valid", rsp_valid[1], 1);
    chk("coll_err", rsp_err[1], 0);
    chk("coll_data", rsp_data[1], 65);
    step();

    // Backpressure
    rsp_ready[1] = 1'b0;
    stub_lat[1]  = 4;
    set_ops(1, 2, 16'd65, 16'd17, 16'd3233);
    req_valid[1] = 4'b0101;
    wait_for(1, 0, 10, c);
    chk("bp_grant", req_ready[1], 4'b0100);
    step();
    req_valid[1] = 4'b0001;
    wait_for(1, 1, 30, c);
    chk("bp_id", rsp_id[1], 2);
    chk("bp_data", rsp_data[1], 2790);
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      smp();
      if (rsp_valid[1] !== 1'b1 || rsp_id[1] !== 2'd2 ||
          rsp_data[1] !== 16'd2790 || req_ready[1] != '0) bad++;
    end
    chk("bp_stable", bad, 0);
    step();
    rsp_ready[1] = 1'b1;
    smp();
    chk("bp_release_valid", rsp_valid[1], 1);
    step();
    smp();
    chk("bp_done_valid", rsp_valid[1], 0);
    chk("bp_next_grant", req_ready[1], 4'b0001);
    step();
    req_valid[1] = '0;
    wait_for(1, 1, 30, c);
    chk("bp_next_data", rsp_data[1], 2);
    step();

    // Reset in the middle of WAIT
    stub_on[1]   = 1'b0;
    core_busy[1] = 1'b0;
    req_valid[1] = 4'b0100;
    smp();
    chk("mr_grant", req_ready[1], 4'b0100);
    step();
    core_busy[1] = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    smp();
    chk_reset_vals(1, "mr");
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      smp();
      if (req_ready[1] != '0) bad++;
    end
    chk("mr_hold_busy", bad, 0);
    step();
    core_busy[1] = 1'b0;
    smp();
    chk("mr_regrant", req_ready[1], 4'b0100);
    step();

    // Randomised traffic against a job-level reference model
    do_reset();
    stub_on[0] = 1'b1;
    begin
      bit          pend[N];
      logic [15:0] oa[N], ok[N], on[N];
      int          wj[N];
      int          ph, mlast, mid, gprev, eg;
      logic [15:0] ma, mk, mn, mres;
      ph = 0; mlast = N - 1; mid = 0; gprev = -1;
      ma = '0; mk = '0; mn = '0; mres = '0;
      for (int i = 0; i < N; i++) begin
        pend[i] = 1'b0;
        wj[i]   = 0;
        oa[i]   = '0; ok[i] = '0; on[i] = '1;
      end
      for (int t = 0; t < 400; t++) begin
        if (gprev >= 0) pend[gprev] = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom_range(3) == 0) begin
            pend[i] = 1'b1;
            oa[i] = 16'($urandom);
            ok[i] = 16'($urandom);
            on[i] = 16'($urandom_range(65535, 1));
            set_ops(0, i, oa[i], ok[i], on[i]);
          end
          req_valid[0][i] = pend[i];
        end
        rsp_ready[0] = ($urandom_range(2) != 0);
        stub_lat[0]  = $urandom_range(12, 1);
        smp();
        eg = -1;
        if (ph == 0 && core_busy[0] === 1'b0 && req_valid[0] != '0)
          eg = rr_pick(req_valid[0], mlast);
        chk("rnd_ready", req_ready[0], eg >= 0 ? 4'b0001 << eg : 4'b0000);
        chk("rnd_start", core_start[0], ph == 1);
        if (ph == 1) begin
          chk("rnd_number", core_number[0], ma);
          chk("rnd_key", core_key[0], mk);
          chk("rnd_n", core_n[0], mn);
        end
        chk("rnd_valid", rsp_valid[0], ph == 3);
        if (ph == 3) begin
          chk("rnd_id", rsp_id[0], mid);
          chk("rnd_data", rsp_data[0], mres);
          chk("rnd_err", rsp_err[0], 0);
        end
        if (ph == 3 && rsp_ready[0]) begin
          ph = 0;
          mlast = mid;
        end else if (ph == 2 && core_finished[0] === 1'b1) begin
          ph = 3;
        end else if (ph == 1) begin
          ph = 2;
        end else if (eg >= 0) begin
          for (int i = 0; i < N; i++)
            if (i != eg && req_valid[0][i]) wj[i]++;
          chk("rnd_fair", wj[eg] <= N - 1, 1);
          wj[eg] = 0;
          ph   = 1;
          mid  = eg;
          ma   = oa[eg]; mk = ok[eg]; mn = on[eg];
          mres = modexp(ma, mk, mn);
        end
        gprev = eg;
        step();
      end
    end

    chk("no_ready_while_busy", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_core_arbiter.md
# rsa_core_arbiter

Round-robin arbiter and sequencer that shares one RSA modular-exponentiation core (16-bit operands, start/busy/finished handshake) among NUM_REQ requesters. It accepts one request at a time and latches its operands. It then pulses the core start, waits for completion under a watchdog, and returns the result tagged with the requester ID on a single valid/ready response channel. It sits between the host-side job sources and the core.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID; equals clog2(NUM_REQ)
- TIMEOUT, 1023, maximum cycles in WAIT before the job is aborted with error (1..65535)
- clk  in  1  clock; everything is on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_number  in  16*NUM_REQ  operand y; requester i at bits [16i+15:16i]
- req_key  in  16*NUM_REQ  exponent, same packing
- req_n  in  16*NUM_REQ  modulus, same packing
- core_start  out  1  one-cycle start pulse to core
- core_number, core_key, core_n  out  16 each  latched operands; stable from ISSUE until the next grant
- core_result  in  16  core result; valid when core_finished=1
- core_finished  in  1  one-cycle completion pulse from core
- core_busy  in  1  core busy
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  requester index of the response
- rsp_data  out  16  result; 0 when rsp_err=1
- rsp_err  out  1  job aborted by watchdog
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid and core_busy=0, grant index g = first asserted req_valid scanning from (last+1) mod NUM_REQ upward with wrap.
  - req_ready[g]=1 combinationally in that cycle only. This is the transfer.
  - Latch g and the three operands of g. Next state ISSUE.
  - If core_busy=1, no grant; all req_ready=0.
- ISSUE: core_start=1 for exactly this cycle. Clear watchdog counter. Next state WAIT.
- WAIT: counter increments every cycle.
  - On core_finished=1: latch core_result, rsp_err=0, go to RESP.
  - Else, when counter == TIMEOUT: rsp_data=0, rsp_err=1, go to RESP.
  - If core_finished and timeout occur in the same cycle, finished wins.
- RESP: rsp_valid=1 with rsp_id=g. Hold all response fields until rsp_ready=1. On that cycle set last=g and go to IDLE.
- core_finished outside WAIT is ignored. This covers late completion after a timeout.
- Requests are never dropped: a requester with req_valid held is granted within NUM_REQ jobs.
- Operands are not range-checked. Width handling is the core's responsibility.

## Timing
- Reset values: state=IDLE, last=NUM_REQ-1 (so requester 0 has first priority), req_ready=0, core_start=0, core_number/key/n=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, counter=0.
- Latencies:
  - Accept cycle A → core_start at A+1.
  - core_finished at cycle F → rsp_valid at F+1.
  - rsp_ready at R → IDLE at R+1; earliest next grant at R+1.
- Minimum turnaround per job: accept + ISSUE + core latency + 1 + response handshake.
- Timeout: rsp_valid rises TIMEOUT+1 cycles after core_start. After a timeout, IDLE holds off granting until core_busy=0.
- rst is asserted mid-job: return to reset values next cycle and discard the pending job. The core is reset separately; the arbiter must not grant while core_busy=1.
- rsp_valid may rise while rsp_ready is already high. The handshake then completes in the first RESP cycle.

## Test plan
- Single request: requester 2 presents number=2790, key=2753, n=3233; the core stub returns 65 after 40 cycles. Expect:
  - req_ready[2] for one cycle
  - core_start the next cycle with operands 2790/2753/3233
  - rsp_valid with rsp_id=2, rsp_data=65, rsp_err=0 one cycle after core_finished
- Round robin: all four req_valid are held from reset, with rsp_ready tied high. Grant order must be 0,1,2,3,0. No req_ready is asserted while busy=1.
- Watchdog: TIMEOUT=20 and the stub never finishes. Expect rsp_err=1, rsp_data=0, rsp_valid 21 cycles after core_start. A stale core_finished arriving later is ignored. No new grant is issued until core_busy falls.
- Backpressure: rsp_ready is held low for 10 cycles. rsp_valid/id/data stay stable, no new grant occurs, and the response completes on the cycle rsp_ready rises.
- Collision: core_finished arrives in the same cycle the counter equals TIMEOUT. Expect rsp_err=0 and rsp_data equal to core_result.
- Reset mid-WAIT: rst is pulsed during WAIT. Next cycle all outputs are at reset values. A subsequent request is granted only after core_busy=0.
